// File: rtl/axis_stream_checker.sv
// Checks a DUT's AXI-Stream output in order against a queue of expected beats, with error/progress counters and stall timeout.
// Latency: expected beat comparable 1 cycle after push; mismatch/vector_done pulse 1 cycle after accept; tready low when empty, halted or ready_en=0.
module axis_stream_checker #(
  parameter int DATA_WIDTH     = 64,
  parameter int DEPTH          = 16,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  exp_valid,
  output logic                  exp_ready,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  exp_last,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  ready_en,
  output logic                  mismatch,
  output logic                  vector_done,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  vector_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic                  error_sticky,
  output logic                  timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [SW-1:0] TO_LIM = SW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t                state_q, state_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [SW-1:0]         stall_q, stall_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  vec_cnt_q, vec_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic                  sticky_q, sticky_d;
  logic                  mismatch_q, vdone_q;

  logic                  empty, full, empty_d, push, pop, beat_err;
  logic [DATA_WIDTH:0]   head;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign exp_ready     = !full && !rst;
  assign s_axis_tready = (state_q == RUN) && !empty && ready_en;

  assign push     = exp_valid && exp_ready && !clear;
  assign pop      = s_axis_tvalid && s_axis_tready && !clear;
  assign beat_err = pop && ((s_axis_tdata != head[DATA_WIDTH-1:0]) || (s_axis_tlast != head[DATA_WIDTH]));

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  assign empty_d  = (wr_ptr_d == rd_ptr_d);

  always_comb begin
    stall_d    = '0;
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    vec_cnt_d  = vec_cnt_q;
    err_cnt_d  = err_cnt_q;
    sticky_d   = sticky_q;

    if (TIMEOUT_CYCLES != 0 && state_q == RUN && !empty && !pop)
      stall_d = stall_q + SW'(1);

    case (state_q)
      IDLE: if (!empty_d) state_d = RUN;
      RUN: begin
        if (TIMEOUT_CYCLES != 0 && stall_d == TO_LIM) state_d = HALT;
        else if (empty_d)                             state_d = IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    // Vector boundaries follow the expected last flag, never the DUT's tlast.
    if (pop) begin
      if (head[DATA_WIDTH]) begin
        beat_cnt_d = '0;
        vec_cnt_d  = vec_cnt_q + CNT_WIDTH'(1);
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
      end
    end
    if (beat_err) begin
      sticky_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      stall_q    <= '0;
      beat_cnt_q <= '0;
      vec_cnt_q  <= '0;
      err_cnt_q  <= '0;
      sticky_q   <= 1'b0;
      mismatch_q <= 1'b0;
      vdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      stall_q    <= stall_d;
      beat_cnt_q <= beat_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      err_cnt_q  <= err_cnt_d;
      sticky_q   <= sticky_d;
      mismatch_q <= beat_err;
      vdone_q    <= pop && head[DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {exp_last, exp_data};
  end

  assign mismatch     = mismatch_q;
  assign vector_done  = vdone_q;
  assign beat_count   = beat_cnt_q;
  assign vector_count = vec_cnt_q;
  assign error_count  = err_cnt_q;
  assign error_sticky = sticky_q;
  assign timeout      = (state_q == HALT);

endmodule
